// File: rtl/axi_master_bridge_pkg.sv
// Shared constants for the SRAM-to-AXI4 master bridge: AXI encodings,
// transaction ids and the read/write FSM state encodings.
package axi_master_bridge_pkg;

    // AXI burst / size encodings used by single-beat transactions
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [2:0] SIZE_8B    = 3'b011;

    // Transaction ids: fetches and load/store traffic are tagged separately
    localparam int ID_INST = 0;
    localparam int ID_DATA = 1;

    // Owner of the in-flight read
    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    // Read FSM states
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_AR   = 2'd1;
    localparam logic [1:0] R_R    = 2'd2;

    // Write FSM states
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_AW_W = 2'd1;
    localparam logic [1:0] W_B    = 2'd2;

endpackage

// File: rtl/axi_master_bridge_wr_ch.sv
// Write half of the bridge: holds one accepted store, drives the AW and W
// channels independently, then waits for the B response and signals
// completion with a one-cycle pulse.
//
// Handshake rule on every AXI channel: a transfer happens on a rising edge
// where valid and ready are both high; valid and payload are held stable
// until that edge and valid never waits on ready.
module axi_master_wr_ch
    import axi_master_bridge_pkg::*;
#(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 64,
    parameter int ID_WD   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    // store accepted this cycle (already qualified by the parent)
    input  logic               store_accept,
    input  logic [ADDR_WD-1:0] st_addr,
    input  logic [2:0]         st_size,
    input  logic [7:0]         st_wstrb,
    input  logic [DATA_WD-1:0] st_wdata,
    output logic [1:0]         wr_state,
    output logic               wr_done,
    // AW channel
    output logic               awvalid,
    input  logic               awready,
    output logic [ID_WD-1:0]   awid,
    output logic [ADDR_WD-1:0] awaddr,
    output logic [7:0]         awlen,
    output logic [2:0]         awsize,
    output logic [1:0]         awburst,
    // W channel
    output logic               wvalid,
    input  logic               wready,
    output logic [DATA_WD-1:0] wdata,
    output logic [7:0]         wstrb,
    output logic               wlast,
    // B channel
    input  logic               bvalid,
    output logic               bready
);

    logic [1:0]         state_q, state_d;
    logic               aw_pend_q, aw_pend_d;
    logic               w_pend_q, w_pend_d;
    logic [ADDR_WD-1:0] addr_q, addr_d;
    logic [2:0]         size_q, size_d;
    logic [7:0]         strb_q, strb_d;
    logic [DATA_WD-1:0] data_q, data_d;
    logic               done_q, done_d;

    // Next-state logic: AW and W retire independently, B closes the store
    always_comb begin
        state_d   = state_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        addr_d    = addr_q;
        size_d    = size_q;
        strb_d    = strb_q;
        data_d    = data_q;
        done_d    = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (store_accept) begin
                    addr_d    = st_addr;
                    size_d    = st_size;
                    strb_d    = st_wstrb;
                    data_d    = st_wdata;
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                    state_d   = W_AW_W;
                end
            end
            W_AW_W: begin
                if (aw_pend_q && awready) aw_pend_d = 1'b0;
                if (w_pend_q && wready)   w_pend_d  = 1'b0;
                // both channels finished (now or earlier) -> wait for response
                if ((!aw_pend_q || awready) && (!w_pend_q || wready)) begin
                    state_d = W_B;
                end
            end
            W_B: begin
                if (bvalid) begin
                    done_d  = 1'b1;
                    state_d = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    // State and payload registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= W_IDLE;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            strb_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            strb_q    <= strb_d;
            data_q    <= data_d;
            done_q    <= done_d;
        end
    end

    assign wr_state = state_q;
    assign wr_done  = done_q;

    assign awvalid  = aw_pend_q;
    assign awid     = ID_WD'(ID_DATA);
    assign awaddr   = addr_q;
    assign awlen    = 8'd0;
    assign awsize   = size_q;
    assign awburst  = BURST_INCR;

    assign wvalid   = w_pend_q;
    assign wdata    = data_q;
    assign wstrb    = strb_q;
    assign wlast    = 1'b1;

    assign bready   = (state_q == W_B);

endmodule

// File: rtl/axi_master_bridge.sv
// Bridges the core's fetch and load/store SRAM-like ports onto one AXI4
// master. One read and one write may be outstanding at once. Loads beat
// fetches for the read channel; a load waits for any store in progress and a
// store waits for any load in progress, so the two never race.
//
// Handshake rule on every AXI channel: a transfer happens on a rising edge
// where valid and ready are both high; valid and payload are held stable
// until that edge and valid never waits on ready. On the SRAM side a request
// is taken in the cycle *_addr_ok is high, and *_data_ok is a one-cycle pulse.
module axi_master_bridge
    import axi_master_bridge_pkg::*;
#(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 64,
    parameter int ID_WD   = 4
) (
    input  logic               clk,
    input  logic               reset,
    // fetch port
    input  logic               inst_req,
    input  logic [ADDR_WD-1:0] inst_addr,
    output logic               inst_addr_ok,
    output logic               inst_data_ok,
    output logic [DATA_WD-1:0] inst_rdata,
    // load/store port
    input  logic               data_req,
    input  logic               data_wr,
    input  logic [2:0]         data_size,
    input  logic [ADDR_WD-1:0] data_addr,
    input  logic [7:0]         data_wstrb,
    input  logic [DATA_WD-1:0] data_wdata,
    output logic               data_addr_ok,
    output logic               data_data_ok,
    output logic [DATA_WD-1:0] data_rdata,
    // AW channel
    output logic               io_master_awvalid,
    input  logic               io_master_awready,
    output logic [ID_WD-1:0]   io_master_awid,
    output logic [ADDR_WD-1:0] io_master_awaddr,
    output logic [7:0]         io_master_awlen,
    output logic [2:0]         io_master_awsize,
    output logic [1:0]         io_master_awburst,
    // W channel
    output logic               io_master_wvalid,
    input  logic               io_master_wready,
    output logic [DATA_WD-1:0] io_master_wdata,
    output logic [7:0]         io_master_wstrb,
    output logic               io_master_wlast,
    // B channel
    input  logic               io_master_bvalid,
    output logic               io_master_bready,
    input  logic [ID_WD-1:0]   io_master_bid,
    input  logic [1:0]         io_master_bresp,
    // AR channel
    output logic               io_master_arvalid,
    input  logic               io_master_arready,
    output logic [ID_WD-1:0]   io_master_arid,
    output logic [ADDR_WD-1:0] io_master_araddr,
    output logic [7:0]         io_master_arlen,
    output logic [2:0]         io_master_arsize,
    output logic [1:0]         io_master_arburst,
    // R channel
    input  logic               io_master_rvalid,
    output logic               io_master_rready,
    input  logic [ID_WD-1:0]   io_master_rid,
    input  logic [DATA_WD-1:0] io_master_rdata,
    input  logic [1:0]         io_master_rresp,
    input  logic               io_master_rlast
);

    logic [1:0]         rd_state_q, rd_state_d;
    logic               rd_owner_q, rd_owner_d;
    logic [ADDR_WD-1:0] rd_addr_q, rd_addr_d;
    logic [2:0]         rd_size_q, rd_size_d;
    logic [DATA_WD-1:0] rd_data_q, rd_data_d;
    logic               inst_ok_q, inst_ok_d;
    logic               load_ok_q, load_ok_d;

    logic [1:0]         wr_state;
    logic               wr_done;
    logic               w_idle;
    logic               rd_idle;
    logic               load_owned;
    logic               load_accept;
    logic               fetch_accept;
    logic               store_accept;

    // Responses carry no information this bridge acts on
    logic               unused_resp;
    assign unused_resp = ^{io_master_bid, io_master_bresp, io_master_rid, io_master_rresp};

    // Arbitration: accepts are masked by reset so no addr_ok leaks while held
    always_comb begin
        w_idle       = (wr_state == W_IDLE);
        rd_idle      = (rd_state_q == R_IDLE);
        load_owned   = !rd_idle && (rd_owner_q == OWNER_DATA);
        load_accept  = reset && rd_idle && data_req && !data_wr && w_idle;
        fetch_accept = reset && rd_idle && inst_req && !load_accept;
        store_accept = reset && data_req && data_wr && w_idle && !load_owned;
    end

    assign inst_addr_ok = fetch_accept;
    assign data_addr_ok = load_accept || store_accept;

    // Read FSM next-state: latch the winner, issue AR, capture the last beat
    always_comb begin
        rd_state_d = rd_state_q;
        rd_owner_d = rd_owner_q;
        rd_addr_d  = rd_addr_q;
        rd_size_d  = rd_size_q;
        rd_data_d  = rd_data_q;
        inst_ok_d  = 1'b0;
        load_ok_d  = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (load_accept) begin
                    rd_owner_d = OWNER_DATA;
                    rd_addr_d  = data_addr;
                    rd_size_d  = data_size;
                    rd_state_d = R_AR;
                end else if (fetch_accept) begin
                    rd_owner_d = OWNER_INST;
                    rd_addr_d  = inst_addr;
                    rd_size_d  = SIZE_4B;
                    rd_state_d = R_AR;
                end
            end
            R_AR: begin
                if (io_master_arready) rd_state_d = R_R;
            end
            R_R: begin
                if (io_master_rvalid && io_master_rlast) begin
                    rd_data_d  = io_master_rdata;
                    inst_ok_d  = (rd_owner_q == OWNER_INST);
                    load_ok_d  = (rd_owner_q == OWNER_DATA);
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Read FSM registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_state_q <= R_IDLE;
            rd_owner_q <= OWNER_INST;
            rd_addr_q  <= '0;
            rd_size_q  <= '0;
            rd_data_q  <= '0;
            inst_ok_q  <= 1'b0;
            load_ok_q  <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_owner_q <= rd_owner_d;
            rd_addr_q  <= rd_addr_d;
            rd_size_q  <= rd_size_d;
            rd_data_q  <= rd_data_d;
            inst_ok_q  <= inst_ok_d;
            load_ok_q  <= load_ok_d;
        end
    end

    assign io_master_arvalid = (rd_state_q == R_AR);
    assign io_master_arid    = (rd_owner_q == OWNER_DATA) ? ID_WD'(ID_DATA) : ID_WD'(ID_INST);
    assign io_master_araddr  = rd_addr_q;
    assign io_master_arlen   = 8'd0;
    assign io_master_arsize  = rd_size_q;
    assign io_master_arburst = BURST_INCR;
    assign io_master_rready  = (rd_state_q == R_R);

    assign inst_data_ok = inst_ok_q;
    assign inst_rdata   = rd_data_q;
    // load completion and store completion cannot coincide (see gating above)
    assign data_data_ok = load_ok_q || wr_done;
    assign data_rdata   = rd_data_q;

    axi_master_wr_ch #(
        .ADDR_WD (ADDR_WD),
        .DATA_WD (DATA_WD),
        .ID_WD   (ID_WD)
    ) u_wr_ch (
        .clk          (clk),
        .rst_n        (reset),
        .store_accept (store_accept),
        .st_addr      (data_addr),
        .st_size      (data_size),
        .st_wstrb     (data_wstrb),
        .st_wdata     (data_wdata),
        .wr_state     (wr_state),
        .wr_done      (wr_done),
        .awvalid      (io_master_awvalid),
        .awready      (io_master_awready),
        .awid         (io_master_awid),
        .awaddr       (io_master_awaddr),
        .awlen        (io_master_awlen),
        .awsize       (io_master_awsize),
        .awburst      (io_master_awburst),
        .wvalid       (io_master_wvalid),
        .wready       (io_master_wready),
        .wdata        (io_master_wdata),
        .wstrb        (io_master_wstrb),
        .wlast        (io_master_wlast),
        .bvalid       (io_master_bvalid),
        .bready       (io_master_bready)
    );

endmodule

// File: tb/tb_axi_master_bridge.sv
// Directed bench for axi_master_bridge: the AXI slave side is driven by hand
// cycle by cycle, and every expected value is written out as a constant.
module tb_axi_master_bridge;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [63:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [2:0]  data_size;
    logic [31:0] data_addr;
    logic [7:0]  data_wstrb;
    logic [63:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [63:0] data_rdata;
    logic        awvalid, awready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    int checks = 0;
    int errors = 0;

    axi_master_bridge dut (
        .clk               (clk),
        .reset             (reset),
        .inst_req          (inst_req),
        .inst_addr         (inst_addr),
        .inst_addr_ok      (inst_addr_ok),
        .inst_data_ok      (inst_data_ok),
        .inst_rdata        (inst_rdata),
        .data_req          (data_req),
        .data_wr           (data_wr),
        .data_size         (data_size),
        .data_addr         (data_addr),
        .data_wstrb        (data_wstrb),
        .data_wdata        (data_wdata),
        .data_addr_ok      (data_addr_ok),
        .data_data_ok      (data_data_ok),
        .data_rdata        (data_rdata),
        .io_master_awvalid (awvalid),
        .io_master_awready (awready),
        .io_master_awid    (awid),
        .io_master_awaddr  (awaddr),
        .io_master_awlen   (awlen),
        .io_master_awsize  (awsize),
        .io_master_awburst (awburst),
        .io_master_wvalid  (wvalid),
        .io_master_wready  (wready),
        .io_master_wdata   (wdata),
        .io_master_wstrb   (wstrb),
        .io_master_wlast   (wlast),
        .io_master_bvalid  (bvalid),
        .io_master_bready  (bready),
        .io_master_bid     (bid),
        .io_master_bresp   (bresp),
        .io_master_arvalid (arvalid),
        .io_master_arready (arready),
        .io_master_arid    (arid),
        .io_master_araddr  (araddr),
        .io_master_arlen   (arlen),
        .io_master_arsize  (arsize),
        .io_master_arburst (arburst),
        .io_master_rvalid  (rvalid),
        .io_master_rready  (rready),
        .io_master_rid     (rid),
        .io_master_rdata   (rdata),
        .io_master_rresp   (rresp),
        .io_master_rlast   (rlast)
    );

    // clock: 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance to 2 ns after the next rising edge; inputs are driven here
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0;
        data_wstrb = '0; data_wdata = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
        arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;

        // ---------------- reset values ----------------
        tick();
        inst_req = 1'b1;
        #1;
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_rready", rready, 0);
        chk("rst_awlen", awlen, 0);
        chk("rst_arlen", arlen, 0);
        chk("rst_awburst", awburst, 2'b01);
        chk("rst_arburst", arburst, 2'b01);
        chk("rst_wlast", wlast, 1);
        chk("rst_araddr", araddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_inst_data_ok", inst_data_ok, 0);
        inst_req = 1'b0;
        tick();
        reset = 1'b1;

        // ---------------- 1: single fetch ----------------
        tick();
        inst_req = 1'b1; inst_addr = 32'h8000_0000;
        #1;
        chk("t1_addr_ok", inst_addr_ok, 1);
        chk("t1_arvalid_T", arvalid, 0);
        tick();
        inst_req = 1'b0; arready = 1'b1;
        #1;
        chk("t1_arvalid", arvalid, 1);
        chk("t1_arid", arid, 0);
        chk("t1_arsize", arsize, 3'd2);
        chk("t1_araddr", araddr, 32'h8000_0000);
        tick();
        arready = 1'b0;
        #1;
        chk("t1_rready", rready, 1);
        chk("t1_arvalid_done", arvalid, 0);
        tick();
        rvalid = 1'b1; rlast = 1'b1; rdata = 64'h0000_0013_0000_0093;
        #1;
        chk("t1_data_ok_early", inst_data_ok, 0);
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        chk("t1_data_ok", inst_data_ok, 1);
        chk("t1_rdata", inst_rdata, 64'h0000_0013_0000_0093);
        chk("t1_data_data_ok", data_data_ok, 0);
        tick();
        #1;
        chk("t1_data_ok_pulse", inst_data_ok, 0);

        // ---------------- 2: load beats fetch ----------------
        tick();
        inst_req = 1'b1; inst_addr = 32'h8000_0008;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_1000; data_size = 3'd3;
        #1;
        chk("t2_data_addr_ok", data_addr_ok, 1);
        chk("t2_inst_addr_ok", inst_addr_ok, 0);
        tick();
        data_req = 1'b0; arready = 1'b1;
        #1;
        chk("t2_arid", arid, 1);
        chk("t2_arsize", arsize, 3'd3);
        chk("t2_araddr", araddr, 32'h8000_1000);
        chk("t2_inst_blocked", inst_addr_ok, 0);
        tick();
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 64'hDEAD_BEEF_0102_0304;
        #1;
        chk("t2_inst_blocked2", inst_addr_ok, 0);
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        chk("t2_data_data_ok", data_data_ok, 1);
        chk("t2_data_rdata", data_rdata, 64'hDEAD_BEEF_0102_0304);
        chk("t2_inst_data_ok", inst_data_ok, 0);
        chk("t2_fetch_accept", inst_addr_ok, 1);
        tick();
        inst_req = 1'b0; arready = 1'b1;
        #1;
        chk("t2_f_arid", arid, 0);
        chk("t2_f_araddr", araddr, 32'h8000_0008);
        tick();
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 64'h0000_0000_1111_2222;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        chk("t2_f_data_ok", inst_data_ok, 1);
        chk("t2_f_rdata", inst_rdata, 64'h0000_0000_1111_2222);

        // ---------------- 3: store with late awready ----------------
        tick();
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8000_1008; data_size = 3'd3;
        data_wstrb = 8'h0F; data_wdata = 64'h0000_0000_1122_3344; wready = 1'b1;
        #1;
        chk("t3_addr_ok", data_addr_ok, 1);
        tick();
        data_req = 1'b0; data_wr = 1'b0;
        #1;
        chk("t3_awvalid1", awvalid, 1);
        chk("t3_wvalid1", wvalid, 1);
        chk("t3_awaddr", awaddr, 32'h8000_1008);
        chk("t3_awid", awid, 1);
        chk("t3_awsize", awsize, 3'd3);
        chk("t3_wstrb", wstrb, 8'h0F);
        chk("t3_wdata", wdata, 64'h0000_0000_1122_3344);
        chk("t3_wlast", wlast, 1);
        tick();
        #1;
        chk("t3_wvalid_drop", wvalid, 0);
        chk("t3_awvalid2", awvalid, 1);
        chk("t3_bready_early", bready, 0);
        tick();
        awready = 1'b1;
        #1;
        chk("t3_awvalid3", awvalid, 1);
        tick();
        awready = 1'b0; wready = 1'b0;
        #1;
        chk("t3_awvalid_drop", awvalid, 0);
        chk("t3_bready", bready, 1);
        tick();
        bvalid = 1'b1;
        #1;
        chk("t3_ok_early", data_data_ok, 0);
        tick();
        bvalid = 1'b0;
        #1;
        chk("t3_data_ok", data_data_ok, 1);
        chk("t3_bready_drop", bready, 0);
        tick();
        #1;
        chk("t3_data_ok_pulse", data_data_ok, 0);

        // ---------------- 4: load held off by store, fetch runs ----------------
        tick();
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8000_2000; data_size = 3'd3;
        data_wstrb = 8'hFF; data_wdata = 64'hA5A5_A5A5_5A5A_5A5A;
        #1;
        chk("t4_st_accept", data_addr_ok, 1);
        tick();
        data_req = 1'b0; awready = 1'b1; wready = 1'b1;
        #1;
        chk("t4_aw_w_same", awvalid & wvalid, 1);
        tick();
        awready = 1'b0; wready = 1'b0;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_2000; data_size = 3'd3;
        inst_req = 1'b1; inst_addr = 32'h8000_0010;
        #1;
        chk("t4_bready", bready, 1);
        chk("t4_load_blocked", data_addr_ok, 0);
        chk("t4_fetch_accept", inst_addr_ok, 1);
        tick();
        inst_req = 1'b0; arready = 1'b1;
        #1;
        chk("t4_f_arid", arid, 0);
        chk("t4_f_araddr", araddr, 32'h8000_0010);
        chk("t4_load_blocked2", data_addr_ok, 0);
        tick();
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 64'h0000_0444_0000_0444;
        tick();
        rvalid = 1'b0; rlast = 1'b0; bvalid = 1'b1;
        #1;
        chk("t4_f_data_ok", inst_data_ok, 1);
        chk("t4_f_rdata", inst_rdata, 64'h0000_0444_0000_0444);
        chk("t4_load_blocked3", data_addr_ok, 0);
        tick();
        bvalid = 1'b0;
        #1;
        chk("t4_st_done", data_data_ok, 1);
        chk("t4_load_accept", data_addr_ok, 1);
        tick();
        data_req = 1'b0; arready = 1'b1;
        #1;
        chk("t4_l_arid", arid, 1);
        chk("t4_l_araddr", araddr, 32'h8000_2000);
        tick();
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 64'h5555_6666_7777_8888;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        chk("t4_l_data_ok", data_data_ok, 1);
        chk("t4_l_rdata", data_rdata, 64'h5555_6666_7777_8888);

        // ---------------- 5: async reset during AR ----------------
        tick();
        inst_req = 1'b1; inst_addr = 32'h8000_0020;
        tick();
        arready = 1'b0;
        #1;
        chk("t5_arvalid_before", arvalid, 1);
        reset = 1'b0;
        #1;
        chk("t5_arvalid_async", arvalid, 0);
        chk("t5_addr_ok_in_reset", inst_addr_ok, 0);
        tick();
        tick();
        reset = 1'b1; inst_addr = 32'h8000_0004;
        #1;
        chk("t5_fresh_accept", inst_addr_ok, 1);
        tick();
        inst_req = 1'b0; arready = 1'b1;
        #1;
        chk("t5_araddr", araddr, 32'h8000_0004);
        chk("t5_arid", arid, 0);
        tick();
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 64'h0000_0006_0000_0006;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        chk("t5_data_ok", inst_data_ok, 1);
        chk("t5_rdata", inst_rdata, 64'h0000_0006_0000_0006);

        // ---------------- 6: back-to-back fetches ----------------
        tick();
        arready = 1'b1; rvalid = 1'b1; rlast = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inst_req = 1'b1; inst_addr = 32'h8000_0100 + 32'(8 * i);
            #1;
            chk("t6_accept", inst_addr_ok, 1);
            if (i > 0) begin
                chk("t6_data_ok", inst_data_ok, 1);
                chk("t6_rdata", inst_rdata, 64'h7000_0000_0000_0000 + 64'(i - 1));
            end
            tick();
            inst_req = 1'b0;
            #1;
            chk("t6_araddr", araddr, 32'h8000_0100 + 32'(8 * i));
            chk("t6_no_accept", inst_addr_ok, 0);
            tick();
            rdata = 64'h7000_0000_0000_0000 + 64'(i);
            #1;
            chk("t6_rready", rready, 1);
            tick();
        end
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        #1;
        chk("t6_last_data_ok", inst_data_ok, 1);
        chk("t6_last_rdata", inst_rdata, 64'h7000_0000_0000_0002);
        chk("t6_idle_no_accept", inst_addr_ok, 0);
        tick();
        #1;
        chk("t6_pulse_end", inst_data_ok, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
